// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : ID-stage hazard bundle between the pipeline and the hazard
//                controller. Carries the register compare inputs, the MDU
//                request inputs and the forwarding/stall/MDU outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // ID stage
    logic             id_valid;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic             use_rs;
    logic             use_rt;
    // EXE stage
    logic [4:0]       ern;
    logic             ewreg;
    logic             em2reg;
    // MEM stage
    logic [4:0]       mrn;
    logic             mwreg;
    logic             mm2reg;
    // MDU requests from ID
    logic             id_mdu_op;
    logic             id_mdu_div;
    logic             id_hilo_rd;
    // Controller outputs
    logic [1:0]       fwda;
    logic [1:0]       fwdb;
    logic             wpcir;
    logic             bubble;
    logic             mdu_start;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cnt;

    // Pipeline side: drives the stage information, consumes the controls
    modport master (
        output id_valid, rs, rt, use_rs, use_rt,
        output ern, ewreg, em2reg, mrn, mwreg, mm2reg,
        output id_mdu_op, id_mdu_div, id_hilo_rd,
        input  fwda, fwdb, wpcir, bubble,
        input  mdu_start, mdu_busy, mdu_done, stall_cnt
    );

    // Hazard controller side
    modport slave (
        input  id_valid, rs, rt, use_rs, use_rt,
        input  ern, ewreg, em2reg, mrn, mwreg, mm2reg,
        input  id_mdu_op, id_mdu_div, id_hilo_rd,
        output fwda, fwdb, wpcir, bubble,
        output mdu_start, mdu_busy, mdu_done, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Forwarding select, load-use interlock and multi-cycle MDU
//                scheduler for a 5-stage pipeline. Counts stalled cycles
//                with a saturating performance counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // Down-counter load values: busy lasts N cycles, counting N-1 .. 0
    localparam logic [5:0]       c_MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0]       c_DIV_LOAD = 6'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_cnt;
    logic [5:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [1:0]       w_fwda;
    logic [1:0]       w_fwdb;
    logic             w_luh;
    logic             w_mh;
    logic             w_stall;
    logic             w_busy;
    logic             w_start;
    logic             w_done;

    // EXE ALU result beats MEM; loads in EXE cannot forward; r0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (bus.ewreg && (bus.ern == src) && (src != 5'd0) && !bus.em2reg)
            sel = 2'b01;
        else if (bus.mwreg && (bus.mrn == src) && (src != 5'd0))
            sel = bus.mm2reg ? 2'b11 : 2'b10;
        return sel;
    endfunction

    // Operand forwarding and hazard detection; reset forces a held, bubbled ID
    always_comb begin
        w_fwda  = reset ? 2'b00 : fwd_sel(bus.rs);
        w_fwdb  = reset ? 2'b00 : fwd_sel(bus.rt);
        w_luh   = bus.id_valid && bus.ewreg && bus.em2reg && (bus.ern != 5'd0) &&
                  ((bus.use_rs && (bus.ern == bus.rs)) ||
                   (bus.use_rt && (bus.ern == bus.rt)));
        w_busy  = (r_state == S_BUSY) && !reset;
        w_mh    = bus.id_valid && (bus.id_mdu_op || bus.id_hilo_rd) && w_busy;
        w_stall = reset || w_luh || w_mh;
    end

    // MDU sequencer next state; a load-use stall defers the launch one cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset && bus.id_valid && bus.id_mdu_op && !w_luh) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = bus.id_mdu_div ? c_DIV_LOAD : c_MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == 6'd0) begin
                    w_done      = !reset;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    // MDU sequencer state and busy counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Saturating count of cycles in which PC and IF/ID were held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign bus.fwda      = w_fwda;
    assign bus.fwdb      = w_fwdb;
    assign bus.wpcir     = !w_stall;
    assign bus.bubble    = w_stall;
    assign bus.mdu_start = w_start;
    assign bus.mdu_busy  = w_busy;
    assign bus.mdu_done  = w_done;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Interlock, forwarding and multi-cycle-unit scheduler for the 5-stage pipeline.
- Sits beside the ID stage. Compares the ID source registers against the EXE and MEM destinations.
- Drives the da/db operand-select muxes and the PC/IF-ID write enable (wpcir).
- Inserts bubbles into ID/EXE.
- Sequences a shared multi-cycle multiply/divide unit (MDU), stalling ID while the unit is busy.

Parameters:
MUL_CYCLES, 4, cycles the MDU is busy for mult/multu (>=1)
DIV_CYCLES, 32, cycles the MDU is busy for div/divu (>=1)
CNT_W, 32, width of the stall performance counter

Ports:
clock  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
id_valid  in  1  ID holds a real instruction (0 = bubble)
rs  in  5  ID inst[25:21]
rt  in  5  ID inst[20:16]
use_rs  in  1  ID instruction reads rs
use_rt  in  1  ID instruction reads rt
ern  in  5  EXE destination register
ewreg  in  1  EXE writes register
em2reg  in  1  EXE is a load
mrn  in  5  MEM destination register
mwreg  in  1  MEM writes register
mm2reg  in  1  MEM is a load
id_mdu_op  in  1  ID is mult/multu/div/divu
id_mdu_div  in  1  with id_mdu_op: 1 = divide, 0 = multiply
id_hilo_rd  in  1  ID is mfhi/mflo
fwda  out  2  da select: 00 regfile qa, 01 ealu, 10 malu, 11 mmo
fwdb  out  2  db select, same encoding, for rt
wpcir  out  1  1 = PC and IF/ID registers may load; 0 = hold
bubble  out  1  1 = ID/EXE loads a NOP (dwreg/dwmem/dm2reg forced 0 by the ID stage)
mdu_start  out  1  one-cycle launch pulse to the MDU
mdu_busy  out  1  MDU occupied
mdu_done  out  1  last busy cycle of the MDU
stall_cnt  out  CNT_W  count of cycles with wpcir=0

Behaviour:
Forwarding (combinational, rs shown; rt identical with use_rt/fwdb):
- Register 0 is never forwarded.
- EXE match has priority over MEM match.
- ewreg & ern==rs & ern!=0 & ~em2reg -> 01.
- Otherwise mwreg & mrn==rs & mrn!=0 -> 10 if ~mm2reg, 11 if mm2reg.
- Otherwise -> 00.

Load-use hazard, luh (combinational):
- luh = id_valid & ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)).

MDU hazard, mh:
- mh = id_valid & (id_mdu_op | id_hilo_rd) & mdu_busy.

Stall:
- stall = luh | mh; wpcir = ~stall; bubble = stall.
- Exactly one bubble is inserted per stalled cycle.
- A load-use stall lasts exactly 1 cycle.

MDU FSM, states IDLE / BUSY, 6-bit down-counter cnt:
- IDLE: if id_valid & id_mdu_op & ~luh, then mdu_start=1 (combinational, same cycle). At the clock edge: cnt <= (id_mdu_div ? DIV_CYCLES : MUL_CYCLES) - 1, state -> BUSY.
- BUSY: mdu_busy=1. cnt decrements each cycle. mdu_done=1 when cnt==0. At that edge, state -> IDLE.
- Busy length is exactly N cycles after the start edge.
- A dependent mfhi/mflo, or a second MDU op, waiting in ID stalls for all N BUSY cycles. It proceeds in the first IDLE cycle; a second MDU op launches in that same cycle.
- mdu_start is never asserted in BUSY or during reset.

stall_cnt:
- Increments on every edge with wpcir=0.
- Saturates at all-ones; no wrap.

Reset (asynchronous, overrides everything, including mid-MDU-operation):
- state=IDLE, cnt=0, stall_cnt=0.
- While reset is high: wpcir=0, bubble=1, fwda=fwdb=00, mdu_start=0, mdu_busy=0, mdu_done=0.
- The MDU shares this reset; no abort handshake exists.
- After reset deasserts, the first edge behaves as IDLE with no hazards.

Simultaneous events:
- luh and an IDLE mdu_op in the same cycle: stall only, no mdu_start. The launch occurs the following cycle.
- mdu_done cycle with a waiting mfhi: still stalled that cycle.

Test Plan:
- Forwarding priority: EXE writes r5 (alu), MEM writes r5 (alu), ID rs=r5, rt=r5 -> fwda=01, fwdb=01. Then EXE stops writing -> both 10. MEM is a load -> both 11. rs=rt=r0 with matching r0 dests -> 00.
- Load-use: lw r3 in EXE, ID "add r4,r3,r2" with use_rs -> exactly 1 cycle wpcir=0, bubble=1, stall_cnt=1. The next cycle gives fwda=11, wpcir=1.
- mult then mfhi, MUL_CYCLES=4: mdu_start at cycle T; mdu_busy during T+1..T+4; mdu_done at T+4. mfhi in ID from T+1 stalls 4 cycles and issues at T+5. stall_cnt=4.
- div back-to-back: second div waits the full 32 BUSY cycles. Its mdu_start asserts in the first IDLE cycle, with no gap cycle.
- Reset mid-divide at busy cycle 10 -> immediately mdu_busy=0, wpcir=0, bubble=1, stall_cnt=0. After release, mdu_op in ID launches on the first cycle.
- Saturation with CNT_W=4: hold luh for 20 cycles -> stall_cnt stops at 15.
